// File: rtl/soc_switches_ctrl.sv
// rtl/soc_switches_ctrl.sv - debounced switch inputs with edge capture and irq, Avalon-MM slave
// Raw pins pass a two-flop synchronizer, a per-bit stability counter, then edge capture.
module soc_switches_ctrl #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STABLE  = 2'd0;
  localparam logic [1:0] ADDR_SYNC    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            irqmask_q, irqmask_d;
  logic [WIDTH-1:0]            edgecap_q, edgecap_d;
  logic [31:0]                 readdata_q, readdata_d;
  logic                        irq_q, irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edgecap_clr;

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // Any sample that agrees with the current stable value restarts that bit's count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    wr_en       = chipselect & ~write_n;
    edge_set    = stable_d ^ stable_q;
    edgecap_clr = '0;
    irqmask_d   = irqmask_q;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGECAP)) begin
      edgecap_clr = writedata[WIDTH-1:0];
    end
    // New edges are OR-ed in after the clear so a coincident set survives.
    edgecap_d = (edgecap_q & ~edgecap_clr) | edge_set;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STABLE:  readdata_d = 32'(stable_q);
      ADDR_SYNC:    readdata_d = 32'(sync2_q);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase
    irq_d = |(edgecap_q & irqmask_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_switches_ctrl.sv
// tb/tb_soc_switches_ctrl.sv - directed self-checking bench for soc_switches_ctrl
// Debounce length 4: an in_port value first sampled at edge s reaches stable at edge s+5.
module tb_soc_switches_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  in_port;
  logic        irq;

  int checks;
  int errors;

  soc_switches_ctrl #(
    .WIDTH(10),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic settle(input logic [9:0] v);
    in_port = v;
    repeat (8) tick();
    wr(2'd3, 32'h3FF);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_port = 10'h3FF;
    address = 2'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: readdata=%h irq=%b, want 0/0", k, readdata, irq);
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) begin
        checks++;
        if (readdata !== 32'h0) begin
          errors++;
          $display("FAIL startup_early: readdata=%h, want 0", readdata);
        end
      end
      if (k == 7) begin
        checks++;
        if (readdata !== 32'h3FF) begin
          errors++;
          $display("FAIL startup_stable: readdata=%h, want 3ff", readdata);
        end
      end
    end
    address = 2'd3;
    tick();
    checks++;
    if (readdata !== 32'h0000_03FF || irq !== 1'b0) begin
      errors++;
      $display("FAIL startup_edgecap: readdata=%h irq=%b, want 000003ff/0", readdata, irq);
    end
  endtask

  task automatic test_bounce();
    address = 2'd0;
    for (int k = 0; k <= 11; k++) begin
      in_port[0] = (k == 3) ? 1'b0 : 1'b1;
      address    = (k == 10) ? 2'd3 : 2'd0;
      tick();
      if (k <= 9) begin
        checks++;
        if (readdata !== 32'h0) begin
          errors++;
          $display("FAIL bounce_hold k%0d: readdata=%h, want 0", k, readdata);
        end
      end else if (k == 10) begin
        checks++;
        if (readdata !== 32'h1) begin
          errors++;
          $display("FAIL bounce_edgecap: readdata=%h, want 1", readdata);
        end
      end else begin
        checks++;
        if (readdata !== 32'h1) begin
          errors++;
          $display("FAIL bounce_stable: readdata=%h, want 1", readdata);
        end
      end
    end
  endtask

  task automatic test_mask();
    wr(2'd2, 32'h001);
    in_port = 10'h020;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL mask_blocked k%0d: irq=%b, want 0", k, irq);
      end
    end
    address = 2'd3;
    tick();
    checks++;
    if (readdata !== 32'h020) begin
      errors++;
      $display("FAIL mask_edgecap5: readdata=%h, want 020", readdata);
    end
    in_port = 10'h021;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        checks++;
        if (readdata !== 32'h020 || irq !== 1'b0) begin
          errors++;
          $display("FAIL mask_pre: readdata=%h irq=%b, want 020/0", readdata, irq);
        end
      end
      if (k == 6) begin
        checks++;
        if (readdata !== 32'h021 || irq !== 1'b1) begin
          errors++;
          $display("FAIL mask_irq_rise: readdata=%h irq=%b, want 021/1", readdata, irq);
        end
      end
    end
    wr(2'd2, 32'h000);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL mask_irq_lag: irq=%b, want 1", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mask_irq_fall: irq=%b, want 0", irq);
    end
  endtask

  task automatic test_w1c();
    wr(2'd3, 32'h001);
    address = 2'd3;
    tick();
    checks++;
    if (readdata !== 32'h020) begin
      errors++;
      $display("FAIL w1c_clear: readdata=%h, want 020", readdata);
    end
    in_port = 10'h020;
    repeat (5) tick();
    wr(2'd3, 32'h001);
    address = 2'd3;
    tick();
    checks++;
    if (readdata !== 32'h021) begin
      errors++;
      $display("FAIL w1c_collision: readdata=%h, want 021", readdata);
    end
    address = 2'd0;
    tick();
    checks++;
    if (readdata !== 32'h020) begin
      errors++;
      $display("FAIL w1c_stable: readdata=%h, want 020", readdata);
    end
  endtask

  task automatic test_read_mux();
    wr(2'd2, 32'h2A5);
    in_port = 10'h120;
    tick();
    tick();
    address = 2'd0;
    tick();
    checks++;
    if (readdata !== 32'h0000_0020) begin
      errors++;
      $display("FAIL mux_stable: readdata=%h, want 00000020", readdata);
    end
    address = 2'd1;
    tick();
    checks++;
    if (readdata !== 32'h0000_0120) begin
      errors++;
      $display("FAIL mux_sync: readdata=%h, want 00000120", readdata);
    end
    address = 2'd2;
    tick();
    checks++;
    if (readdata !== 32'h0000_02A5) begin
      errors++;
      $display("FAIL mux_irqmask: readdata=%h, want 000002a5", readdata);
    end
    address = 2'd3;
    tick();
    checks++;
    if (readdata !== 32'h0000_0021) begin
      errors++;
      $display("FAIL mux_edgecap: readdata=%h, want 00000021", readdata);
    end
    wr(2'd0, 32'hFFFF_FFFF);
    checks++;
    if (readdata !== 32'h0000_0120) begin
      errors++;
      $display("FAIL mux_wr0_ignored: readdata=%h, want 00000120", readdata);
    end
    wr(2'd1, 32'hFFFF_FFFF);
    checks++;
    if (readdata !== 32'h0000_0120) begin
      errors++;
      $display("FAIL mux_wr1_ignored: readdata=%h, want 00000120", readdata);
    end
    address = 2'd2;
    tick();
    checks++;
    if (readdata !== 32'h0000_02A5 || irq !== 1'b1) begin
      errors++;
      $display("FAIL mux_irqmask_kept: readdata=%h irq=%b, want 000002a5/1", readdata, irq);
    end
    address = 2'd3;
    tick();
    checks++;
    if (readdata !== 32'h0000_0121) begin
      errors++;
      $display("FAIL mux_edgecap8: readdata=%h, want 00000121", readdata);
    end
  endtask

  task automatic test_reset_mid();
    address = 2'd0;
    in_port = 10'h004;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: readdata=%h irq=%b, want 0/0", readdata, irq);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (k < 7 && readdata !== 32'h0) begin
        errors++;
        $display("FAIL midreset_early k%0d: readdata=%h, want 0", k, readdata);
      end else if (k == 7 && readdata !== 32'h004) begin
        errors++;
        $display("FAIL midreset_rise: readdata=%h, want 004", readdata);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    test_reset();
    settle(10'h000);
    test_bounce();
    settle(10'h000);
    test_mask();
    test_w1c();
    test_read_mux();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
